// File: rtl/fp_switch_ctrl_pkg.sv
// Shared encodings for the front-panel switch conditioner: FSM state codes
// and the default channel assignment of the PDP-8/e front-panel switches.
package fp_switch_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_PULSE   = 3'd2;
  localparam logic [2:0] ST_HOLDOFF = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam int CH_CLEAR     = 6;
  localparam int CH_EXTD_ADDR = 5;
  localparam int CH_ADDR_LOAD = 4;
  localparam int CH_DEP       = 3;
  localparam int CH_EXAM      = 2;
  localparam int CH_CONT      = 1;
  localparam int CH_DSEL      = 0;

endpackage

// File: rtl/fp_sync2.sv
// Parametrised-width two-flop synchroniser for asynchronous switch levels.
module fp_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: non-blocking assignments let both stages sample their pre-edge values,
  // giving a true two-flop chain instead of a single collapsed register.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fp_switch_ctrl.sv
// Front-panel switch conditioner: synchronise, latch, one-shot pulse, hold-off,
// wait for release. Optional auto-repeat of held switches under FP_AUTO_REPEAT_EN.
module fp_switch_ctrl
  import fp_switch_ctrl_pkg::*;
#(
  parameter int                NUM_SW      = 7,
  parameter int                DSEL_IDX    = CH_DSEL,
  parameter int                DSEL_W      = 6,
  parameter int                PULSE_LEN   = 3,
  parameter int                DBNCE_BITS  = 4,
  parameter int                REPEAT_BITS = 20,
  parameter logic [NUM_SW-1:0] REPEAT_MASK = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_in,
  output logic [NUM_SW-1:0] sw_pulse,
  output logic              trigger,
  output logic              sw_active,
  output logic              armed,
  output logic [DSEL_W-1:0] dsel
);

  localparam int PCNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [DSEL_W-1:0] DSEL_RST = DSEL_W'(1) << (DSEL_W - 1);

  logic [NUM_SW-1:0]   sw_s;
  logic [NUM_SW-1:0]   latch;
  logic [2:0]          state;
  logic [PCNT_W-1:0]   pcnt;
  logic [DBNCE_BITS:0] hcnt;
  logic                repeat_fire;
  logic [NUM_SW-1:0]   held;

  fp_sync2 #(.W(NUM_SW)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_in),
    .q     (sw_s)
  );

  assign held      = sw_s & REPEAT_MASK;
  assign armed     = (state == ST_IDLE);
  // Drops on the terminal hold-off cycle so the flag spans exactly 2^DBNCE_BITS cycles.
  assign sw_active = (state == ST_HOLDOFF) && !hcnt[DBNCE_BITS];

`ifdef FP_AUTO_REPEAT_EN
  logic [NUM_SW-1:0]    held_q;
  logic [REPEAT_BITS:0] rcnt;

  // Fires only when the repeatable set has stayed identical for the whole interval.
  assign repeat_fire = rcnt[REPEAT_BITS] && (held == held_q);

  always_ff @(posedge clk) begin
    if (reset || state != ST_RELEASE) begin
      rcnt   <= '0;
      held_q <= '0;
    end else begin
      held_q <= held;
      if (held == '0 || held != held_q || rcnt[REPEAT_BITS])
        rcnt <= '0;
      else
        rcnt <= rcnt + (REPEAT_BITS+1)'(1);
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      latch    <= '0;
      sw_pulse <= '0;
      trigger  <= 1'b0;
      pcnt     <= '0;
      hcnt     <= '0;
      dsel     <= DSEL_RST;
    end else begin
      case (state)
        ST_IDLE: begin
          latch <= latch | sw_s;
          if (latch != '0) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          sw_pulse <= latch;
          trigger  <= 1'b1;
          latch    <= '0;
          pcnt     <= PCNT_W'(1);
          state    <= ST_PULSE;
        end
        ST_PULSE: begin
          if (pcnt == PCNT_W'(1) && sw_pulse[DSEL_IDX])
            dsel <= {dsel[0], dsel[DSEL_W-1:1]};
          if (pcnt == PCNT_W'(PULSE_LEN)) begin
            sw_pulse <= '0;
            trigger  <= 1'b0;
            hcnt     <= '0;
            state    <= ST_HOLDOFF;
          end else begin
            pcnt <= pcnt + PCNT_W'(1);
          end
        end
        ST_HOLDOFF: begin
          hcnt <= hcnt + (DBNCE_BITS+1)'(1);
          if (hcnt[DBNCE_BITS]) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (sw_s == '0) begin
            state <= ST_IDLE;
          end else if (repeat_fire) begin
            latch <= held;
            state <= ST_CAPTURE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
